// File: rtl/s1_fetch_sequencer_pkg.sv
// Shared encodings for the stage-1 fetch sequencer: redirect selects,
// memory region tags, the NOP used on faulting fetches and FSM states.
// Pure declarations; no latency or flow control of its own.
package s1_fetch_sequencer_pkg;

  // Stage-3 redirect select encodings
  localparam logic [1:0] PC_SEL_SEQ     = 2'd0;
  localparam logic [1:0] PC_SEL_REDIR   = 2'd1;
  localparam logic [1:0] PC_SEL_RSVD    = 2'd2;
  localparam logic [1:0] PC_SEL_RESTART = 2'd3;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  // Address-space regions, decoded from addr[31:28]
  localparam logic [3:0] REGION_BIOS = 4'h4;
  localparam logic [3:0] REGION_IMEM = 4'h1;

  typedef enum logic [1:0] {
    FS_BOOT  = 2'd0,
    FS_RUN   = 2'd1,
    FS_FLUSH = 2'd2
  } fetch_state_e;

  // True when the select moves the PC off the sequential stream
  function automatic logic is_redirect(input logic [1:0] sel);
    return (sel == PC_SEL_REDIR) || (sel == PC_SEL_RESTART);
  endfunction

  // True when an address lies in a fetchable region
  function automatic logic in_fetch_region(input logic [31:0] addr);
    return (addr[31:28] == REGION_BIOS) || (addr[31:28] == REGION_IMEM);
  endfunction

endpackage

// File: rtl/fetch_perf_counters.sv
// Fetch performance counters: useful fetches and bubble cycles, saturating.
// Latency: counts reflect the previous cycle's activity (one register stage).
// Backpressure: none; samples status every cycle, stall only gates fetch_cnt.
// Only built when FETCH_PERF_EN is defined; otherwise this file is empty so
// the default build carries no orphan module.
`ifdef FETCH_PERF_EN
module fetch_perf_counters (
  input  logic        clk,
  input  logic        rst,
  input  logic        perf_clr,
  input  logic        inst_valid,
  input  logic        stall,
  output logic [31:0] fetch_cnt,
  output logic [31:0] bubble_cnt
);

  // Count valid instructions that actually advance into stage 2
  always_ff @(posedge clk) begin
    if (rst || perf_clr) begin
      fetch_cnt <= 32'd0;
    end else if (inst_valid && !stall && (fetch_cnt != 32'hFFFF_FFFF)) begin
      fetch_cnt <= fetch_cnt + 32'd1;
    end
  end

  // Count cycles where stage 1 holds no correct-path instruction
  always_ff @(posedge clk) begin
    if (rst || perf_clr) begin
      bubble_cnt <= 32'd0;
    end else if (!inst_valid && (bubble_cnt != 32'hFFFF_FFFF)) begin
      bubble_cnt <= bubble_cnt + 32'd1;
    end
  end

endmodule
`endif

// File: rtl/s1_fetch_sequencer.sv
// Fetch sequencer: owns the PC, addresses BIOS/IMEM, steers the returned word
// into stage 1 and kills wrong-path slots on stage-3 redirects.
// Latency: one cycle from fetch_addr to inst_s1 (synchronous-read memories).
// Backpressure: stall freezes the PC and re-reads the same address so stage-1
// outputs stay stable; a redirect overrides stall.
// Optional: FETCH_PERF_EN adds perf_clr/perf_fetch_cnt/perf_bubble_cnt.
module s1_fetch_sequencer
  import s1_fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h4000_0000,
  parameter int unsigned BOOT_BUBBLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  pc_sel_s3,
  input  logic [31:0] target_s3,
  input  logic        stall,
  input  logic [31:0] bios_dout,
  input  logic [31:0] imem_dout,
  output logic [31:0] fetch_addr,
  output logic        bios_en,
  output logic        imem_en,
  output logic [31:0] pc_s1,
  output logic [31:0] inst_s1,
  output logic        inst_valid_s1,
  output logic        flush_s2,
  output logic        fetch_fault
`ifdef FETCH_PERF_EN
  ,
  input  logic        perf_clr,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_bubble_cnt
`endif
);

  // Last value of the boot counter before leaving BOOT
  localparam logic [2:0] BOOT_LAST = 3'(BOOT_BUBBLES - 1);

  logic [31:0]  pc_q;
  logic [2:0]   boot_cnt_q;
  fetch_state_e state_q, state_d;
  logic [1:0]   sel_eff;
  logic         redirect;
  logic [31:0]  target_aligned;
  logic         unused_target_lsb;

  // Misaligned target bits are dropped; keep them referenced for lint
  assign target_aligned    = {target_s3[31:2], 2'b00};
  assign unused_target_lsb = ^target_s3[1:0];

  // Stage 3 holds nothing valid during boot, so its select is ignored there
  always_comb begin
    sel_eff  = (state_q == FS_BOOT) ? PC_SEL_SEQ : pc_sel_s3;
    redirect = is_redirect(sel_eff);
  end

  // Next-PC selection: reset, restart, redirect, stall hold, then sequential
  always_comb begin
    fetch_addr = 32'(pc_q + 32'd4);
    if (rst) begin
      fetch_addr = RESET_PC;
    end else if (sel_eff == PC_SEL_RESTART) begin
      fetch_addr = RESET_PC;
    end else if (sel_eff == PC_SEL_REDIR) begin
      fetch_addr = target_aligned;
    end else if (stall) begin
      fetch_addr = pc_q;
    end
  end

  // Region-decoded read enables; a held PC keeps re-reading the same word
  assign bios_en = (fetch_addr[31:28] == REGION_BIOS);
  assign imem_en = (fetch_addr[31:28] == REGION_IMEM);

  // PC register tracks whatever address was just presented to memory
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= fetch_addr;
    end
  end

  // FSM state and boot-bubble counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FS_BOOT;
      boot_cnt_q <= 3'd0;
    end else begin
      state_q <= state_d;
      if (state_q == FS_BOOT) begin
        boot_cnt_q <= boot_cnt_q + 3'd1;
      end
    end
  end

  // Next state plus valid/flush outputs for the word currently in stage 1
  always_comb begin
    state_d       = state_q;
    inst_valid_s1 = 1'b0;
    flush_s2      = 1'b0;
    case (state_q)
      FS_BOOT: begin
        if (boot_cnt_q == BOOT_LAST) begin
          state_d = FS_RUN;
        end
      end
      FS_RUN, FS_FLUSH: begin
        flush_s2      = redirect;
        inst_valid_s1 = !redirect && !fetch_fault;
        state_d       = redirect ? FS_FLUSH : FS_RUN;
      end
      default: begin
        state_d = FS_BOOT;
      end
    endcase
  end

  // Steer the memory that owns pc_q; anything else is a fault fed a NOP
  always_comb begin
    pc_s1       = pc_q;
    fetch_fault = !in_fetch_region(pc_q);
    inst_s1     = NOP_INST;
    if (pc_q[31:28] == REGION_BIOS) begin
      inst_s1 = bios_dout;
    end else if (pc_q[31:28] == REGION_IMEM) begin
      inst_s1 = imem_dout;
    end
  end

`ifdef FETCH_PERF_EN
  fetch_perf_counters u_perf (
    .clk        (clk),
    .rst        (rst),
    .perf_clr   (perf_clr),
    .inst_valid (inst_valid_s1),
    .stall      (stall),
    .fetch_cnt  (perf_fetch_cnt),
    .bubble_cnt (perf_bubble_cnt)
  );
`endif

endmodule

// File: tb/tb_s1_fetch_sequencer.sv
// Directed bench for s1_fetch_sequencer: reset/boot, redirect, stall,
// redirect-over-stall, faults, wrap, boot masking and optional perf counters.
module tb_s1_fetch_sequencer;

  logic        clk;
  logic        rst;
  logic [1:0]  pc_sel_s3;
  logic [31:0] target_s3;
  logic        stall;
  logic [31:0] bios_dout;
  logic [31:0] imem_dout;
  logic [31:0] fetch_addr;
  logic        bios_en;
  logic        imem_en;
  logic [31:0] pc_s1;
  logic [31:0] inst_s1;
  logic        inst_valid_s1;
  logic        flush_s2;
  logic        fetch_fault;
`ifdef FETCH_PERF_EN
  logic        perf_clr;
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_bubble_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  s1_fetch_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .pc_sel_s3     (pc_sel_s3),
    .target_s3     (target_s3),
    .stall         (stall),
    .bios_dout     (bios_dout),
    .imem_dout     (imem_dout),
    .fetch_addr    (fetch_addr),
    .bios_en       (bios_en),
    .imem_en       (imem_en),
    .pc_s1         (pc_s1),
    .inst_s1       (inst_s1),
    .inst_valid_s1 (inst_valid_s1),
    .flush_s2      (flush_s2),
    .fetch_fault   (fetch_fault)
`ifdef FETCH_PERF_EN
    ,
    .perf_clr        (perf_clr),
    .perf_fetch_cnt  (perf_fetch_cnt),
    .perf_bubble_cnt (perf_bubble_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memories; each word encodes its own low address bits
  // so every returned instruction is predictable by hand:
  //   BIOS word at A = {16'hB105, A[15:0]}, IMEM word at A = {16'h1EE0, A[15:0]}
  initial begin
    bios_dout = 32'd0;
    imem_dout = 32'd0;
  end
  always @(posedge clk) begin
    if (bios_en) bios_dout <= {16'hB105, fetch_addr[15:0]};
    if (imem_en) imem_dout <= {16'h1EE0, fetch_addr[15:0]};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; pc_sel_s3 = 2'd0; target_s3 = 32'd0; stall = 1'b0;
`ifdef FETCH_PERF_EN
    perf_clr = 1'b0;
`endif
    tick(); tick(); #1;
    n_tests++; if (pc_s1 !== 32'h4000_0000) begin n_fail++; $display("FAIL reset_pc: got %h want 40000000", pc_s1); end
    n_tests++; if (inst_valid_s1 !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", inst_valid_s1); end
    n_tests++; if (flush_s2 !== 1'b0 || fetch_fault !== 1'b0) begin n_fail++; $display("FAIL reset_flush_fault: got %b%b want 00", flush_s2, fetch_fault); end
    n_tests++; if (fetch_addr !== 32'h4000_0000 || bios_en !== 1'b1) begin n_fail++; $display("FAIL reset_fetch_addr: got %h/%b want 40000000/1", fetch_addr, bios_en); end
    // First cycle after release: boot bubble, PC already advancing
    rst = 1'b0; #1;
    n_tests++; if (inst_valid_s1 !== 1'b0 || pc_s1 !== 32'h4000_0000) begin n_fail++; $display("FAIL boot_bubble: got valid=%b pc=%h want 0/40000000", inst_valid_s1, pc_s1); end
    n_tests++; if (fetch_addr !== 32'h4000_0004) begin n_fail++; $display("FAIL boot_fetch_addr: got %h want 40000004", fetch_addr); end
    tick(); #1;
    n_tests++; if (pc_s1 !== 32'h4000_0004 || inst_valid_s1 !== 1'b1) begin n_fail++; $display("FAIL first_valid: got pc=%h valid=%b want 40000004/1", pc_s1, inst_valid_s1); end
    n_tests++; if (inst_s1 !== 32'hB105_0004) begin n_fail++; $display("FAIL first_inst: got %h want b1050004", inst_s1); end
    tick(); #1;
    n_tests++; if (pc_s1 !== 32'h4000_0008 || inst_valid_s1 !== 1'b1) begin n_fail++; $display("FAIL second_valid: got pc=%h valid=%b want 40000008/1", pc_s1, inst_valid_s1); end
  endtask

  task automatic test_redirect();
    tick();
    pc_sel_s3 = 2'd1; target_s3 = 32'h1000_0010; #1;
    n_tests++; if (inst_valid_s1 !== 1'b0 || flush_s2 !== 1'b1) begin n_fail++; $display("FAIL redir_kill: got valid=%b flush=%b want 0/1", inst_valid_s1, flush_s2); end
    n_tests++; if (fetch_addr !== 32'h1000_0010 || imem_en !== 1'b1 || bios_en !== 1'b0) begin n_fail++; $display("FAIL redir_addr: got %h imem=%b bios=%b want 10000010/1/0", fetch_addr, imem_en, bios_en); end
    tick();
    pc_sel_s3 = 2'd0; #1;
    n_tests++; if (pc_s1 !== 32'h1000_0010 || inst_valid_s1 !== 1'b1 || flush_s2 !== 1'b0) begin n_fail++; $display("FAIL redir_target: got pc=%h valid=%b flush=%b want 10000010/1/0", pc_s1, inst_valid_s1, flush_s2); end
    n_tests++; if (inst_s1 !== 32'h1EE0_0010 || fetch_addr !== 32'h1000_0014) begin n_fail++; $display("FAIL redir_inst: got %h addr=%h want 1ee00010/10000014", inst_s1, fetch_addr); end
  endtask

  task automatic test_back_to_back();
    // Misaligned target then an immediate second redirect
    tick();
    pc_sel_s3 = 2'd1; target_s3 = 32'h1000_0043; #1;
    n_tests++; if (fetch_addr !== 32'h1000_0040) begin n_fail++; $display("FAIL misaligned: got %h want 10000040", fetch_addr); end
    tick();
    pc_sel_s3 = 2'd1; target_s3 = 32'h4000_0020; #1;
    n_tests++; if (pc_s1 !== 32'h1000_0040 || inst_valid_s1 !== 1'b0 || flush_s2 !== 1'b1) begin n_fail++; $display("FAIL b2b_redir: got pc=%h valid=%b flush=%b want 10000040/0/1", pc_s1, inst_valid_s1, flush_s2); end
    tick();
    pc_sel_s3 = 2'd0; #1;
    n_tests++; if (pc_s1 !== 32'h4000_0020 || inst_valid_s1 !== 1'b1) begin n_fail++; $display("FAIL b2b_target: got pc=%h valid=%b want 40000020/1", pc_s1, inst_valid_s1); end
  endtask

  task automatic test_stall();
    // Entered mid-cycle with pc_s1 = 0x4000_0020
    stall = 1'b1; #1;
    n_tests++; if (fetch_addr !== 32'h4000_0020) begin n_fail++; $display("FAIL stall_addr: got %h want 40000020", fetch_addr); end
    for (int i = 0; i < 2; i++) begin
      tick(); #1;
      n_tests++; if (pc_s1 !== 32'h4000_0020 || fetch_addr !== 32'h4000_0020) begin n_fail++; $display("FAIL stall_hold[%0d]: got pc=%h addr=%h want 40000020", i, pc_s1, fetch_addr); end
      n_tests++; if (inst_s1 !== 32'hB105_0020 || inst_valid_s1 !== 1'b1) begin n_fail++; $display("FAIL stall_inst[%0d]: got %h valid=%b want b1050020/1", i, inst_s1, inst_valid_s1); end
    end
    tick();
    stall = 1'b0; #1;
    n_tests++; if (fetch_addr !== 32'h4000_0024) begin n_fail++; $display("FAIL stall_release: got %h want 40000024", fetch_addr); end
    tick(); #1;
    n_tests++; if (pc_s1 !== 32'h4000_0024 || inst_s1 !== 32'hB105_0024) begin n_fail++; $display("FAIL stall_resume: got pc=%h inst=%h want 40000024/b1050024", pc_s1, inst_s1); end
  endtask

  task automatic test_stall_redirect();
    tick();
    stall = 1'b1; pc_sel_s3 = 2'd1; target_s3 = 32'h1000_0100; #1;
    n_tests++; if (fetch_addr !== 32'h1000_0100 || flush_s2 !== 1'b1 || inst_valid_s1 !== 1'b0) begin n_fail++; $display("FAIL stall_redir: got addr=%h flush=%b valid=%b want 10000100/1/0", fetch_addr, flush_s2, inst_valid_s1); end
    tick();
    stall = 1'b0; pc_sel_s3 = 2'd0; #1;
    n_tests++; if (pc_s1 !== 32'h1000_0100 || inst_s1 !== 32'h1EE0_0100 || inst_valid_s1 !== 1'b1) begin n_fail++; $display("FAIL stall_redir_tgt: got pc=%h inst=%h valid=%b want 10000100/1ee00100/1", pc_s1, inst_s1, inst_valid_s1); end
  endtask

  task automatic test_fault();
    tick();
    pc_sel_s3 = 2'd1; target_s3 = 32'h2000_0000;
    tick();
    pc_sel_s3 = 2'd0; #1;
    n_tests++; if (fetch_fault !== 1'b1 || inst_s1 !== 32'h0000_0013 || inst_valid_s1 !== 1'b0) begin n_fail++; $display("FAIL fault: got fault=%b inst=%h valid=%b want 1/00000013/0", fetch_fault, inst_s1, inst_valid_s1); end
    n_tests++; if (bios_en !== 1'b0 || imem_en !== 1'b0) begin n_fail++; $display("FAIL fault_en: got bios=%b imem=%b want 0/0", bios_en, imem_en); end
    tick();
    pc_sel_s3 = 2'd3; #1;
    n_tests++; if (fetch_addr !== 32'h4000_0000 || flush_s2 !== 1'b1) begin n_fail++; $display("FAIL restart: got addr=%h flush=%b want 40000000/1", fetch_addr, flush_s2); end
    tick();
    pc_sel_s3 = 2'd0; #1;
    n_tests++; if (pc_s1 !== 32'h4000_0000 || fetch_fault !== 1'b0 || inst_valid_s1 !== 1'b1) begin n_fail++; $display("FAIL recover: got pc=%h fault=%b valid=%b want 40000000/0/1", pc_s1, fetch_fault, inst_valid_s1); end
  endtask

  task automatic test_wrap_reserved();
    tick();
    pc_sel_s3 = 2'd2; #1;
    n_tests++; if (fetch_addr !== 32'h4000_0008 || flush_s2 !== 1'b0 || inst_valid_s1 !== 1'b1) begin n_fail++; $display("FAIL reserved_sel: got addr=%h flush=%b valid=%b want 40000008/0/1", fetch_addr, flush_s2, inst_valid_s1); end
    pc_sel_s3 = 2'd1; target_s3 = 32'hFFFF_FFFC;
    tick();
    pc_sel_s3 = 2'd0; #1;
    n_tests++; if (pc_s1 !== 32'hFFFF_FFFC || fetch_addr !== 32'h0000_0000 || fetch_fault !== 1'b1) begin n_fail++; $display("FAIL wrap: got pc=%h addr=%h fault=%b want fffffffc/00000000/1", pc_s1, fetch_addr, fetch_fault); end
  endtask

  task automatic test_boot_redirect();
    tick();
    rst = 1'b1; stall = 1'b1; pc_sel_s3 = 2'd1; target_s3 = 32'h1000_0000; #1;
    n_tests++; if (fetch_addr !== 32'h4000_0000 || bios_en !== 1'b1 || imem_en !== 1'b0) begin n_fail++; $display("FAIL rst_wins: got addr=%h bios=%b imem=%b want 40000000/1/0", fetch_addr, bios_en, imem_en); end
    tick();
    rst = 1'b0; stall = 1'b0; #1;
    n_tests++; if (flush_s2 !== 1'b0 || fetch_addr !== 32'h4000_0004 || inst_valid_s1 !== 1'b0) begin n_fail++; $display("FAIL boot_ignore: got flush=%b addr=%h valid=%b want 0/40000004/0", flush_s2, fetch_addr, inst_valid_s1); end
    tick();
    pc_sel_s3 = 2'd0; #1;
    n_tests++; if (pc_s1 !== 32'h4000_0004 || inst_valid_s1 !== 1'b1) begin n_fail++; $display("FAIL boot_exit: got pc=%h valid=%b want 40000004/1", pc_s1, inst_valid_s1); end
  endtask

`ifdef FETCH_PERF_EN
  task automatic test_perf();
    tick();
    rst = 1'b1; pc_sel_s3 = 2'd0; stall = 1'b0;
    tick();
    rst = 1'b0;           // boot bubble cycle
    tick();               // first valid fetch
    for (int i = 0; i < 10; i++) tick();
    pc_sel_s3 = 2'd1; target_s3 = 32'h4000_0000;   // redirect bubble
    tick();
    pc_sel_s3 = 2'd0; #1;
    n_tests++; if (perf_fetch_cnt !== 32'd10 || perf_bubble_cnt !== 32'd2) begin n_fail++; $display("FAIL perf_counts: got %0d/%0d want 10/2", perf_fetch_cnt, perf_bubble_cnt); end
    tick();
    perf_clr = 1'b1;
    tick();
    perf_clr = 1'b0; #1;
    n_tests++; if (perf_fetch_cnt !== 32'd0 || perf_bubble_cnt !== 32'd0) begin n_fail++; $display("FAIL perf_clr: got %0d/%0d want 0/0", perf_fetch_cnt, perf_bubble_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_redirect();
    test_back_to_back();
    test_stall();
    test_stall_redirect();
    test_fault();
    test_wrap_reserved();
    test_boot_redirect();
`ifdef FETCH_PERF_EN
    test_perf();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
